input_stream_cell: RTL and testbench
====================================

Name: input_stream_cell

Overview:
- Front-end feeder for the first weight_comp_cell layer.
- Accepts input-vector words over a valid/ready handshake into a ping-pong buffer of two banks, each WEIGHT_AMOUNT words.
- Emits each complete vector as a contiguous index/value/enable stream, with a constant "no result" sideband on output_result.
- While one bank streams, the next vector loads into the other bank.

Parameters:
- DATA_WIDTH, 32, width of input words and of output_index / output_value.
- WEIGHT_AMOUNT, 4, words per vector; legal range ≥2.
- MIN_GAP, 1, minimum idle cycles (output_enable low) between consecutive streamed vectors; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a valid word.
- in_ready  output  1  buffer can accept a word; a transfer occurs on any edge with in_valid & in_ready.
- in_data  input  DATA_WIDTH  vector element; elements arrive in order, index 0 first.
- output_index  output  DATA_WIDTH  element index 0..WEIGHT_AMOUNT-1.
- output_value  output  DATA_WIDTH  element value.
- output_result  output  DATA_WIDTH+1  constant {1'b0, DATA_WIDTH'b0}; bit DATA_WIDTH low means "no result".
- output_enable  output  1  index/value valid this cycle.
- vector_count  output  16  count of fully streamed vectors; wraps 0xFFFF→0.

Behaviour:
- Reset (async assert, sync release):
  - outputs: output_index=0, output_value=0, output_enable=0, vector_count=0, in_ready=1.
  - state: both bank full flags=0, load_bank=0, load_ptr=0, stream_bank=0, FSM=IDLE, gap counter=0.
  - Asserting reset mid-load or mid-stream discards all buffered data. No partial vector is emitted after release.
- Load side:
  - in_ready = !full[load_bank]; purely combinational from registers, with no dependence on in_valid.
  - On a transfer, write bank[load_bank][load_ptr] and increment load_ptr.
  - When load_ptr reaches WEIGHT_AMOUNT-1 on a transfer: set full[load_bank], load_ptr←0, load_bank toggles.
  - Bubbles on in_valid are allowed anywhere in a vector.
- Stream FSM states: IDLE, STREAM, GAP.
  - IDLE: if full[stream_bank] → STREAM with elem_ptr=0.
  - STREAM: each cycle registers output_enable=1, output_index=elem_ptr, output_value=bank[stream_bank][elem_ptr]; elem_ptr increments.
  - End of STREAM, on the edge emitting element WEIGHT_AMOUNT-1 → next edge:
    - clear full[stream_bank], toggle stream_bank, increment vector_count;
    - go to GAP if MIN_GAP>0, else go directly to IDLE-evaluation, so back-to-back is allowed when the other bank is full.
  - GAP: output_enable=0 for exactly MIN_GAP cycles, then IDLE.
- Output registers outside STREAM: output_enable=0; output_index and output_value return to 0 (deterministic, no X).
- Latency: last word of a vector accepted at edge E0 with stream side idle → output_enable high for the cycle following edge E1 (one clock after acceptance). Index 0 appears first, and the vector occupies exactly WEIGHT_AMOUNT consecutive enable cycles.
- Simultaneous events:
  - The full-flag clear and a load into the same bank in one cycle cannot both occur, because in_ready for that bank is low until the cleared flag is registered. in_ready rises the cycle after the clear.
  - A set and a clear on different banks in the same edge are both honoured.
- Both banks full: in_ready=0 and in_valid is ignored. No data is lost or overwritten.
- All index arithmetic is unsigned. load_ptr and elem_ptr are $clog2(WEIGHT_AMOUNT) bits, zero-extended to DATA_WIDTH on output_index.

Decomposition:
- Shared package nn_pkg:
  - DATA_WIDTH default;
  - RESULT_NONE constant ({1'b0, zeros});
  - the stream FSM state enum (IDLE/STREAM/GAP).
- One sub-module is natural: pingpong_bank, a two-bank register file with a write port, a read port and full flags.
- The top level holds the load pointer, the FSM, the gap counter and the output registers.

Test Plan:
- Reset, then load 1,1,1,1 continuously → one clock after the 4th accept: output_enable high 4 cycles, index 0,1,2,3, value 1 each; output_result=0 throughout; vector_count=1.
- Load vector A=1,2,3,4 then B=5,6,7,8 back-to-back, MIN_GAP=1 → A streamed, exactly 1 cycle enable low, then B streamed; in_ready never drops; vector_count=2.
- Load three vectors with no pauses while stream is in progress → in_ready drops after the second vector completes and rises the cycle after A's bank clears; all 12 values emerge in order with none lost.
- in_valid toggles 1,0,1,0,… during the load of 9,8,7,6 → streamed values 9,8,7,6 at index 0..3; no premature output_enable.
- Assert reset_n=0 asynchronously (mid-clock) during index 2 of a stream → outputs zero immediately; after release no further enable until a fresh full vector is loaded; vector_count=0.
- MIN_GAP=0, two preloaded vectors → 8 consecutive enable cycles with indices 0..3,0..3.

Source files
------------

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared widths, constants and stream FSM states for the nn front end
package nn_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

  // Sideband value meaning "no result": the flag bit (MSB) is low.
  localparam logic [DATA_WIDTH_DEFAULT:0] RESULT_NONE = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } stream_state_t;

endpackage

// File: rtl/input_stream_cell_pingpong_bank.sv
// rtl/input_stream_cell_pingpong_bank.sv - two-bank register file with per-bank full flags
module pingpong_bank #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_wr_en,
  input  logic          i_wr_bank,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_set_full,
  input  logic          i_clr_en,
  input  logic          i_clr_bank,
  input  logic          i_rd_bank,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data,
  output logic [1:0]    o_full
);

  logic [DW-1:0] r_mem [2][DEPTH];
  logic [1:0]    r_full;
  logic [1:0]    w_full_nxt;

  // Word storage; cleared on reset so no stale vector survives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int a = 0; a < DEPTH; a++) begin
          r_mem[b][a] <= '0;
        end
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
    end
  end

  // Full-flag update: a clear on one bank and a set on the other both land
  always_comb begin
    w_full_nxt = r_full;
    if (i_clr_en) begin
      w_full_nxt[i_clr_bank] = 1'b0;
    end
    if (i_wr_en && i_set_full) begin
      w_full_nxt[i_wr_bank] = 1'b1;
    end
  end

  // Full-flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full <= 2'b00;
    end else begin
      r_full <= w_full_nxt;
    end
  end

  assign o_rd_data = r_mem[i_rd_bank][i_rd_addr];
  assign o_full    = r_full;

endmodule

// File: rtl/input_stream_cell.sv
// rtl/input_stream_cell.sv - ping-pong input buffer streaming index/value/enable vectors
module input_stream_cell
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
  parameter int WEIGHT_AMOUNT = 4,
  parameter int MIN_GAP       = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] output_index,
  output logic [DATA_WIDTH-1:0] output_value,
  output logic [DATA_WIDTH:0]   output_result,
  output logic                  output_enable,
  output logic [15:0]           vector_count
);

  localparam int               PTR_W    = (WEIGHT_AMOUNT > 1) ? $clog2(WEIGHT_AMOUNT) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WEIGHT_AMOUNT - 1);
  localparam logic [3:0]       GAP_LEN  = 4'(MIN_GAP);

  logic                  r_load_bank;
  logic [PTR_W-1:0]      r_load_ptr;
  logic                  r_stream_bank;
  logic [PTR_W-1:0]      r_elem_ptr;
  stream_state_t         r_state;
  logic [3:0]            r_gap_cnt;
  logic                  r_out_en;
  logic [DATA_WIDTH-1:0] r_out_idx;
  logic [DATA_WIDTH-1:0] r_out_val;
  logic [15:0]           r_vec_cnt;

  logic [1:0]            w_full;
  logic                  w_xfer;
  logic                  w_last_load;
  logic [DATA_WIDTH-1:0] w_rd_data;
  stream_state_t         w_next_state;
  logic                  w_emit;
  logic                  w_emit_bank;
  logic [PTR_W-1:0]      w_emit_ptr;
  logic                  w_end;
  logic                  w_en_d;
  logic [DATA_WIDTH-1:0] w_idx_d;
  logic [DATA_WIDTH-1:0] w_val_d;

  assign in_ready    = ~w_full[r_load_bank];
  assign w_xfer      = in_valid & in_ready;
  assign w_last_load = w_xfer && (r_load_ptr == LAST_PTR);

  pingpong_bank #(
    .DW    (DATA_WIDTH),
    .DEPTH (WEIGHT_AMOUNT),
    .AW    (PTR_W)
  ) u_bank (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_wr_en    (w_xfer),
    .i_wr_bank  (r_load_bank),
    .i_wr_addr  (r_load_ptr),
    .i_wr_data  (in_data),
    .i_set_full (w_last_load),
    .i_clr_en   (w_end),
    .i_clr_bank (r_stream_bank),
    .i_rd_bank  (w_emit_bank),
    .i_rd_addr  (w_emit_ptr),
    .o_rd_data  (w_rd_data),
    .o_full     (w_full)
  );

  // Load pointer and bank advance on each accepted word; bank flips after the last one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_load_ptr  <= '0;
      r_load_bank <= 1'b0;
    end else if (w_xfer) begin
      if (w_last_load) begin
        r_load_ptr  <= '0;
        r_load_bank <= ~r_load_bank;
      end else begin
        r_load_ptr  <= r_load_ptr + 1'b1;
      end
    end
  end

  // Stream FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, plus which element (if any) gets registered onto the outputs this edge
  always_comb begin
    w_next_state = r_state;
    w_emit       = 1'b0;
    w_emit_bank  = r_stream_bank;
    w_emit_ptr   = '0;
    w_end        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_full[r_stream_bank]) begin
          w_next_state = ST_STREAM;
          w_emit       = 1'b1;
        end
      end
      ST_STREAM: begin
        if (r_elem_ptr == LAST_PTR) begin
          // Last element has been on the outputs for a cycle: release the bank
          w_end = 1'b1;
          if (MIN_GAP > 0) begin
            w_next_state = ST_GAP;
          end else if (w_full[~r_stream_bank]) begin
            w_next_state = ST_STREAM;
            w_emit       = 1'b1;
            w_emit_bank  = ~r_stream_bank;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else begin
          w_emit     = 1'b1;
          w_emit_ptr = r_elem_ptr + 1'b1;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LEN) begin
          if (w_full[r_stream_bank]) begin
            w_next_state = ST_STREAM;
            w_emit       = 1'b1;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output register next values: zeros whenever nothing is emitted
  always_comb begin
    w_en_d  = w_emit;
    w_idx_d = '0;
    w_val_d = '0;
    if (w_emit) begin
      w_idx_d = DATA_WIDTH'(w_emit_ptr);
      w_val_d = w_rd_data;
    end
  end

  // Stream bookkeeping: element pointer, stream bank, gap counter, completed vectors
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_elem_ptr    <= '0;
      r_stream_bank <= 1'b0;
      r_gap_cnt     <= '0;
      r_vec_cnt     <= '0;
    end else begin
      if (w_emit) begin
        r_elem_ptr <= w_emit_ptr;
      end
      if (w_end) begin
        r_stream_bank <= ~r_stream_bank;
        r_vec_cnt     <= r_vec_cnt + 16'd1;
      end
      if (w_end) begin
        r_gap_cnt <= 4'd1;
      end else if (r_state == ST_GAP && w_next_state == ST_GAP) begin
        r_gap_cnt <= r_gap_cnt + 4'd1;
      end else begin
        r_gap_cnt <= '0;
      end
    end
  end

  // Registered stream outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_en  <= 1'b0;
      r_out_idx <= '0;
      r_out_val <= '0;
    end else begin
      r_out_en  <= w_en_d;
      r_out_idx <= w_idx_d;
      r_out_val <= w_val_d;
    end
  end

  assign output_enable = r_out_en;
  assign output_index  = r_out_idx;
  assign output_value  = r_out_val;
  assign output_result = (DATA_WIDTH + 1)'(RESULT_NONE);
  assign vector_count  = r_vec_cnt;

endmodule

// File: tb/tb_input_stream_cell.sv
// tb/tb_input_stream_cell.sv - directed vector bench for input_stream_cell
module tb_input_stream_cell;

  typedef struct packed {
    logic [0:3][31:0] w;
    logic             bubble;
    logic [0:3][31:0] ev;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, in_valid2 = 1'b0;
  logic [31:0] in_data = '0, in_data2 = '0;
  logic        in_ready, in_ready2;
  logic [31:0] o_index, o_value, o_index2, o_value2;
  logic [32:0] o_result, o_result2;
  logic        o_enable, o_enable2;
  logic [15:0] vcount, vcount2;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_acc = 0;

  logic [31:0] cap_idx[$], cap_val[$], cap2_idx[$], cap2_val[$];
  int          cap_cyc[$], cap2_cyc[$];

  vec_t tbl [3];

  input_stream_cell #(.DATA_WIDTH(32), .WEIGHT_AMOUNT(4), .MIN_GAP(1)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .output_index(o_index), .output_value(o_value), .output_result(o_result),
    .output_enable(o_enable), .vector_count(vcount)
  );

  input_stream_cell #(.DATA_WIDTH(32), .WEIGHT_AMOUNT(4), .MIN_GAP(0)) dut_nogap (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .output_index(o_index2), .output_value(o_value2), .output_result(o_result2),
    .output_enable(o_enable2), .vector_count(vcount2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && o_enable) begin
      cap_idx.push_back(o_index);
      cap_val.push_back(o_value);
      cap_cyc.push_back(cyc);
      chk("result_none", 64'(o_result), 64'd0);
    end
    if (reset_n && o_enable2) begin
      cap2_idx.push_back(o_index2);
      cap2_val.push_back(o_value2);
      cap2_cyc.push_back(cyc);
      chk("result_none_nogap", 64'(o_result2), 64'd0);
    end
  end

  task automatic clear_caps();
    cap_idx.delete(); cap_val.delete(); cap_cyc.delete();
    cap2_idx.delete(); cap2_val.delete(); cap2_cyc.delete();
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic push(input bit sel, input logic [31:0] d, output int stalls);
    stalls = 0;
    if (sel) begin in_valid2 = 1'b1; in_data2 = d; end
    else     begin in_valid  = 1'b1; in_data  = d; end
    while (!(sel ? in_ready2 : in_ready) && stalls < 100) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 100) chk("push_ready_timeout", 64'(stalls), 64'd0);
    @(posedge clk);
    @(negedge clk);
    last_acc = cyc;
    in_valid = 1'b0;
    in_valid2 = 1'b0;
  endtask

  task automatic wait_caps(input bit sel, input int n, input int budget);
    int k = 0;
    while (((sel ? cap2_idx.size() : cap_idx.size()) < n) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("capture_count", 64'(sel ? cap2_idx.size() : cap_idx.size()), 64'(n));
  endtask

  initial begin
    int st;
    int acc;
    int drops;
    int k;

    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, acc, drops, k;
    logic found;

    tbl[0].w = {32'd1, 32'd1, 32'd1, 32'd1};
    tbl[0].bubble = 1'b0;
    tbl[0].ev = {32'd1, 32'd1, 32'd1, 32'd1};
    tbl[1].w = {32'd9, 32'd8, 32'd7, 32'd6};
    tbl[1].bubble = 1'b1;
    tbl[1].ev = {32'd9, 32'd8, 32'd7, 32'd6};
    tbl[2].w = {32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 32'h12345678};
    tbl[2].bubble = 1'b0;
    tbl[2].ev = {32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 32'h12345678};

    // Reset state
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_enable", 64'(o_enable), 64'd0);
    chk("rst_index", 64'(o_index), 64'd0);
    chk("rst_value", 64'(o_value), 64'd0);
    chk("rst_result", 64'(o_result), 64'd0);
    chk("rst_vcount", 64'(vcount), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_ready_nogap", 64'(in_ready2), 64'd1);

    // Table: one vector at a time, stream drains before the next
    for (int i = 0; i < 3; i++) begin
      clear_caps();
      for (int j = 0; j < 4; j++) begin
        push(1'b0, tbl[i].w[j], st);
        if (j < 3) chk("t_no_early_enable", 64'(o_enable), 64'd0);
        if (tbl[i].bubble && j < 3) @(negedge clk);
      end
      acc = last_acc;
      wait_caps(1'b0, 4, 20);
      for (int j = 0; j < 4; j++) begin
        chk("t_index", 64'(cap_idx[j]), 64'(j));
        chk("t_value", 64'(cap_val[j]), 64'(tbl[i].ev[j]));
      end
      chk("t_latency", 64'(cap_cyc[0] - acc), 64'd1);
      chk("t_contiguous", 64'(cap_cyc[3] - cap_cyc[0]), 64'd3);
      repeat (4) @(negedge clk);
      chk("t_vcount", 64'(vcount), 64'(i + 1));
    end

    // Two vectors back to back with MIN_GAP=1
    clear_caps();
    drops = 0;
    for (int j = 0; j < 8; j++) begin
      push(1'b0, 32'(j + 1), st);
      drops += st;
    end
    chk("b_ready_drop", 64'(drops), 64'd0);
    wait_caps(1'b0, 8, 40);
    for (int j = 0; j < 8; j++) begin
      chk("b_index", 64'(cap_idx[j]), 64'(j % 4));
      chk("b_value", 64'(cap_val[j]), 64'(j + 1));
    end
    chk("b_gap_one", 64'(cap_cyc[4] - cap_cyc[3]), 64'd2);
    chk("b_contig_a", 64'(cap_cyc[3] - cap_cyc[0]), 64'd3);
    chk("b_contig_b", 64'(cap_cyc[7] - cap_cyc[4]), 64'd3);
    repeat (6) @(negedge clk);
    chk("b_vcount", 64'(vcount), 64'd5);

    // Three vectors with no pauses: one stall on the ninth word
    clear_caps();
    drops = 0;
    for (int j = 0; j < 12; j++) begin
      push(1'b0, 32'(100 + j), st);
      if (j == 8) chk("c_stall_ninth", 64'(st), 64'd1);
      else drops += st;
    end
    chk("c_other_stalls", 64'(drops), 64'd0);
    wait_caps(1'b0, 12, 60);
    for (int j = 0; j < 12; j++) begin
      chk("c_index", 64'(cap_idx[j]), 64'(j % 4));
      chk("c_value", 64'(cap_val[j]), 64'(100 + j));
    end
    repeat (8) @(negedge clk);
    chk("c_vcount", 64'(vcount), 64'd8);

    // Asynchronous reset while index 2 is on the outputs
    clear_caps();
    for (int j = 0; j < 4; j++) push(1'b0, 32'h50 + 32'(j), st);
    k = 0;
    found = 1'b0;
    while (!found && k < 20) begin
      if (o_enable && o_index == 32'd2) found = 1'b1;
      else begin @(negedge clk); k++; end
    end
    chk("d_reach_index2", 64'(found), 64'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("d_async_enable", 64'(o_enable), 64'd0);
    chk("d_async_index", 64'(o_index), 64'd0);
    chk("d_async_value", 64'(o_value), 64'd0);
    chk("d_async_vcount", 64'(vcount), 64'd0);
    chk("d_async_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    clear_caps();
    repeat (20) @(negedge clk);
    chk("d_no_stale_stream", 64'(cap_idx.size()), 64'd0);
    for (int j = 0; j < 4; j++) push(1'b0, 32'hA1 + 32'(j), st);
    acc = last_acc;
    wait_caps(1'b0, 4, 20);
    for (int j = 0; j < 4; j++) begin
      chk("d_fresh_index", 64'(cap_idx[j]), 64'(j));
      chk("d_fresh_value", 64'(cap_val[j]), 64'(32'hA1 + 32'(j)));
    end
    chk("d_fresh_latency", 64'(cap_cyc[0] - acc), 64'd1);
    repeat (4) @(negedge clk);
    chk("d_vcount", 64'(vcount), 64'd1);

    // MIN_GAP=0: two vectors stream as 8 consecutive enables
    clear_caps();
    drops = 0;
    for (int j = 0; j < 8; j++) begin
      push(1'b1, 32'(200 + j), st);
      drops += st;
    end
    chk("e_ready_drop", 64'(drops), 64'd0);
    wait_caps(1'b1, 8, 40);
    for (int j = 0; j < 8; j++) begin
      chk("e_index", 64'(cap2_idx[j]), 64'(j % 4));
      chk("e_value", 64'(cap2_val[j]), 64'(200 + j));
    end
    chk("e_contiguous", 64'(cap2_cyc[7] - cap2_cyc[0]), 64'd7);
    repeat (6) @(negedge clk);
    chk("e_vcount", 64'(vcount2), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
